stream_mux_nx1: RTL
===================

# stream_mux_nx1

Parametrised N-input, W-bit stream multiplexer with valid/ready handshakes, packet locking and a registered output stage. It is the sequential successor of the team's combinational 2:1 gate-level mux. It funnels several packet sources into one downstream sink. Channel choice is either round-robin arbitration or an external select, and a channel is never switched mid-packet.

## Interface
Parameters:
- N, 4: number of input channels; N >= 2.
- W, 8: data width per channel.
- GW, $clog2(N): width of the select and grant fields.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = round-robin arbitration; 1 = fixed select via sel.
- sel  input  GW  channel index used when mode = 1.
- s_valid  input  N  per-channel valid; bit i belongs to channel i.
- s_data  input  N*W  channel i occupies bits [i*W +: W].
- s_last  input  N  per-channel end-of-packet marker.
- s_ready  output  N  per-channel ready; at most one bit is high.
- m_valid  output  1  output beat valid (registered).
- m_data  output  W  output data (registered).
- m_last  output  1  output end-of-packet (registered).
- m_ready  input  1  downstream ready.
- grant  output  GW  currently granted channel (registered).
- busy  output  1  high while in state XFER.

## Operation
- The block has two states, ARB and XFER.
- A beat is accepted on channel i when s_valid[i] && s_ready[i] at a rising edge. A beat is delivered when m_valid && m_ready at a rising edge.
- **ARB state**
  - s_ready is all zero.
  - In mode 0, the winner is the first channel with s_valid set, searching (ptr+1) mod N, (ptr+2) mod N, … upward with wrap.
  - In mode 1, the winner is sel, only if sel < N and s_valid[sel] = 1.
  - If there is a winner: grant <= winner and the state moves to XFER.
  - If there is no winner, or sel >= N in mode 1: stay in ARB; grant holds.
- **XFER state**
  - s_ready[grant] = !m_valid || m_ready. This is combinational from the registered m_valid and from m_ready. All other s_ready bits are 0.
  - An accepted beat loads m_data, m_last and m_valid <= 1.
  - An accepted beat with s_last = 1 sets ptr <= grant and moves the state to ARB.
  - mode and sel changes are ignored until the state returns to ARB.
- **Output register**
  - Accept: m_valid <= 1 and the data/last fields load.
  - Else, if m_ready: m_valid <= 0, and m_data/m_last hold their values.
  - Else: everything holds.
  - m_data and m_last do not change while m_valid && !m_ready.
- **Reset (asynchronous, any time, including mid-packet)**
  - State = ARB, ptr = N-1 (so channel 0 has first priority).
  - grant = 0, m_valid = 0, m_data = 0, m_last = 0, busy = 0.
  - s_ready becomes all zero immediately.
  - A partially transferred packet is abandoned; there is no recovery.

## Timing
- **First-beat latency.** s_valid[i] rises in cycle t while the block is in ARB.
  - Cycle t+1: grant = i and busy = 1.
  - Cycle t+1: s_ready[i] is high if the output register is free, and the beat is accepted at the end of t+1.
  - Cycle t+2: m_valid = 1.
- **Steady state.** One beat per cycle while m_ready = 1. There are no bubbles inside a packet.
- **Packet boundary.**
  - Exactly one ARB cycle separates the last beat of one packet from the first accept of the next.
  - A new grant can be made while the previous last beat still sits in the output register.
- **Backpressure.** With m_ready = 0 and m_valid = 1, s_ready[grant] is 0 and everything holds. When m_ready returns to 1, the held beat is delivered and a new beat is accepted in the same cycle.
- **Single-beat packet.** s_valid and s_last high on the same beat: accept, then return to ARB on the next edge.
- **Round-robin fairness.** With all channels continuously valid, grants go 0,1,…,N-1,0…. A channel waits at most N-1 packets.

## Test plan
- **Reset.** Assert rst_n = 0 mid-packet with m_valid = 1, asynchronously between edges. Required: m_valid, s_ready, busy and grant go to 0 immediately. After release, the first grant goes to channel 0 when all channels are valid.
- **Round-robin.** N=4, W=8, mode 0, all channels sending 2-beat packets, m_ready = 1. Required: m_data order is ch0 beats A0,A1, then ch1 B0,B1, ch2, ch3, ch0. There is exactly one idle m_valid cycle between packets, and m_last is high on every second beat.
- **Fixed mode.** mode 1, sel = 2; channels 1 and 2 both valid with 3-beat packets. Required: only channel 2 is served. Changing sel to 1 after the second beat has no effect until channel 2's last beat has been accepted; channel 1 is then granted one cycle later.
- **Backpressure.** Hold m_ready = 0 for 5 cycles during a 4-beat packet 0x11,0x22,0x33,0x44. Required: m_data holds 0x22 stable with m_valid high, s_ready = 0 for the whole stall, and the stream resumes in order with no beat lost or duplicated.
- **Out-of-range / idle.** mode 1 with sel = 3 at N=3, or no s_valid at all. Required: stay in ARB, s_ready all zero, busy = 0, m_valid = 0 after draining.
- **Single-beat packets.** Back-to-back single-beat packets on channels 0 and 1 (s_last = 1 on every beat). Required: the output alternates 0,1,0,1 at a rate of one beat every 2 cycles.

Source files
------------

// File: rtl/stream_mux_nx1.sv
// rtl/stream_mux_nx1.sv - N-input valid/ready stream mux with packet locking and registered output
module stream_mux_nx1 #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int GW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [GW-1:0]   sel,
  input  logic [N-1:0]    s_valid,
  input  logic [N*W-1:0]  s_data,
  input  logic [N-1:0]    s_last,
  output logic [N-1:0]    s_ready,
  output logic            m_valid,
  output logic [W-1:0]    m_data,
  output logic            m_last,
  input  logic            m_ready,
  output logic [GW-1:0]   grant,
  output logic            busy
);

  typedef enum logic {ST_ARB, ST_XFER} state_e;

  state_e          state_q;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   grant_q;
  logic            m_valid_q;
  logic [W-1:0]    m_data_q;
  logic            m_last_q;

  logic [W-1:0]    ch_data [N];
  logic            rr_found;
  logic [GW-1:0]   rr_idx;
  logic [GW-1:0]   cand;
  logic            sel_ok;
  logic            fx_found;
  logic            win_d;
  logic [GW-1:0]   grant_d;
  logic            out_free;
  logic            accept;

  // Unpack the flat data bus into one word per channel
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = s_data[i*W +: W];
  end

  // Round-robin search starting just after the last channel that finished a packet
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = GW'((32'(ptr_q) + 32'(k)) % 32'(N));
      if (!rr_found && s_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Winner selection: external select only counts when it names a real, valid channel
  always_comb begin
    sel_ok   = (32'(sel) < 32'(N));
    fx_found = sel_ok ? s_valid[sel] : 1'b0;
    win_d    = mode ? fx_found : rr_found;
    grant_d  = mode ? sel : rr_idx;
  end

  // Source handshake: only the granted channel may see ready, and only when the output slot frees up
  always_comb begin
    out_free = !m_valid_q || m_ready;
    accept   = (state_q == ST_XFER) && s_valid[grant_q] && out_free;
    s_ready  = '0;
    if (state_q == ST_XFER) begin
      s_ready[grant_q] = out_free;
    end
  end

  // Arbitration FSM plus the output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARB;
      ptr_q     <= GW'(N-1);
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (win_d) begin
            grant_q <= grant_d;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept && s_last[grant_q]) begin
            ptr_q   <= grant_q;
            state_q <= ST_ARB;
          end
        end
        default: state_q <= ST_ARB;
      endcase

      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= ch_data[grant_q];
        m_last_q  <= s_last[grant_q];
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign grant   = grant_q;
  assign busy    = (state_q == ST_XFER);

endmodule
